rr_log_sched: RTL and testbench

- Scheduler that shares one log output stream among NCH recorded interfaces.
- Each cycle it takes a snapshot of every logb (transaction-start) and loge (transaction-end) channel. It then serializes the snapshot as one header word, followed by the logb payloads in ascending channel order.
- Sits between the per-interface twoway-handshake split loggers and the log buffer/DMA writer.
- logb acceptance is all-or-nothing across channels, so stalls are global. loge is never stalled.

---
 rtl/rr_log_pkg.sv | 28 ++
 rtl/rr_lowest_bit.sv | 21 ++
 rtl/rr_log_sched.sv | 169 ++++++++++++++++
 tb/tb_rr_log_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_log_pkg.sv
// Shared types and helpers for the round-robin log scheduler.
package rr_log_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData
  } state_e;

  // Widest header the helpers handle; callers cast down to their word width.
  localparam int unsigned HdrMaxW = 256;

  function automatic int unsigned ts_w(input int unsigned nch, input int unsigned dw);
    return dw - 2 * nch;
  endfunction

  function automatic bit dw_ok(input int unsigned nch, input int unsigned dw);
    return dw >= 2 * nch + 8;
  endfunction

  function automatic logic [HdrMaxW-1:0] hdr_pack(input logic [HdrMaxW-1:0] ts,
                                                  input logic [HdrMaxW-1:0] emask,
                                                  input logic [HdrMaxW-1:0] bmask,
                                                  input int unsigned nch);
    return (ts << (2 * nch)) | (emask << nch) | bmask;
  endfunction

endpackage

// File: rtl/rr_lowest_bit.sv
// Combinational priority encoder: index and one-hot of the lowest set mask bit.
module rr_lowest_bit #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [Width-1:0] mask_i,
  output logic [IdxW-1:0]  idx_o,
  output logic [Width-1:0] onehot_o
);

  assign onehot_o = mask_i & (~mask_i + Width'(1));

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/rr_log_sched.sv
// Serialises per-cycle logb/loge snapshots into header + payload records.
// Optional counters enabled by defining RR_LOG_SCHED_STATS_EN.
module rr_log_sched
  import rr_log_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NCH-1:0]          logb_valid,
  output logic [NCH-1:0]          logb_ready,
  input  logic [NCH*DATA_WIDTH-1:0] logb_data,
  input  logic [NCH-1:0]          loge_valid,
  output logic [NCH-1:0]          loge_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
`ifdef RR_LOG_SCHED_STATS_EN
  output logic [31:0]             stat_records,
  output logic [31:0]             stat_stall_cycles,
`endif
  output logic                    loge_ovf
);

  localparam int unsigned TS_WIDTH = ts_w(NCH, DATA_WIDTH);
  localparam int unsigned IdxW     = (NCH > 1) ? $clog2(NCH) : 1;

  if (!dw_ok(NCH, DATA_WIDTH)) begin : gen_bad_width
    $error("rr_log_sched: DATA_WIDTH must be >= 2*NCH+8");
  end

  state_e                state_q, state_d;
  logic [NCH-1:0]        bmask_q, bmask_d;
  logic [NCH-1:0]        pend_q, pend_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] payload_q [NCH];

  logic                  capture;
  logic [NCH-1:0]        cur_oh, nxt_oh, rem;
  logic [IdxW-1:0]       cur_idx, nxt_idx;

  assign capture = (state_q == StIdle) && ((|logb_valid) || (|loge_valid) || (|pend_q));
  assign rem     = bmask_q & ~cur_oh;

  rr_lowest_bit #(.Width(NCH), .IdxW(IdxW)) u_cur (
    .mask_i  (bmask_q),
    .idx_o   (cur_idx),
    .onehot_o(cur_oh)
  );

  rr_lowest_bit #(.Width(NCH), .IdxW(IdxW)) u_nxt (
    .mask_i  (rem),
    .idx_o   (nxt_idx),
    .onehot_o(nxt_oh)
  );

  always_comb begin
    state_d     = state_q;
    bmask_d     = bmask_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    // A capture folds the incoming loge into the header, so it consumes pend.
    pend_d      = capture ? '0 : (pend_q | loge_valid);
    ovf_d       = ovf_q | (!capture && |(pend_q & loge_valid));
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d     = StHdr;
          bmask_d     = logb_valid;
          out_valid_d = 1'b1;
          out_last_d  = ~|logb_valid;
          out_data_d  = DATA_WIDTH'(hdr_pack(HdrMaxW'(ts_q), HdrMaxW'(pend_q | loge_valid),
                                             HdrMaxW'(logb_valid), NCH));
        end
      end
      StHdr: begin
        if (out_ready) begin
          if (|bmask_q) begin
            state_d    = StData;
            out_data_d = payload_q[cur_idx];
            out_last_d = (bmask_q == cur_oh);
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end
        end
      end
      StData: begin
        if (out_ready) begin
          bmask_d = rem;
          if (rem == '0) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            out_data_d = payload_q[nxt_idx];
            out_last_d = (rem == nxt_oh);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      bmask_q     <= '0;
      pend_q      <= '0;
      ts_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bmask_q     <= bmask_d;
      pend_q      <= pend_d;
      ts_q        <= ts_q + TS_WIDTH'(1);
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (capture && logb_valid[i]) payload_q[i] <= logb_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef RR_LOG_SCHED_STATS_EN
  logic [31:0] rec_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rec_q   <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid_q && out_ready && out_last_q && (rec_q != '1)) rec_q <= rec_q + 32'd1;
      if (out_valid_q && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_records      = rec_q;
  assign stat_stall_cycles = stall_q;
`else
  // Default build carries no statistics state.
`endif

  assign logb_ready = {NCH{state_q == StIdle}};
  assign loge_ready = '1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign loge_ovf   = ovf_q;

endmodule

// File: tb/tb_rr_log_sched.sv
// Directed self-checking bench for rr_log_sched (NCH=4, DATA_WIDTH=32).
module tb_rr_log_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NCH-1:0]  logb_valid = '0;
  logic [NCH-1:0]  logb_ready;
  logic [NCH*DW-1:0] logb_data = '0;
  logic [NCH-1:0]  loge_valid = '0;
  logic [NCH-1:0]  loge_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            loge_ovf;
`ifdef RR_LOG_SCHED_STATS_EN
  logic [31:0]     stat_records;
  logic [31:0]     stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int tb_ts  = 0;
  int ts_exp = 0;

  always #5 clk = ~clk;

  rr_log_sched #(.NCH(NCH), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .logb_valid       (logb_valid),
    .logb_ready       (logb_ready),
    .logb_data        (logb_data),
    .loge_valid       (loge_valid),
    .loge_ready       (loge_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
`ifdef RR_LOG_SCHED_STATS_EN
    .stat_records     (stat_records),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .loge_ovf         (loge_ovf)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample #1 after the edge; tb_ts mirrors the free-running ts.
  task automatic step();
    @(posedge clk);
    #1;
    if (rstn) tb_ts++;
    else tb_ts = 0;
  endtask

  task automatic wait_ts(input int t);
    for (int n = 0; n < 1000 && tb_ts != t; n++) step();
    check_val("wait_ts", 64'(tb_ts), 64'(t));
  endtask

  function automatic logic [31:0] hdr(input int t, input logic [3:0] e, input logic [3:0] b);
    logic [23:0] tt;
    tt = t[23:0];
    return {tt, e, b};
  endfunction

  task automatic expect_word(input string tag, input logic [31:0] d, input logic l);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_data"}, 64'(out_data), 64'(d));
    check_val({tag, "_last"}, 64'(out_last), 64'(l));
  endtask

  task automatic expect_idle(input string tag);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_bready"}, 64'(logb_ready), 64'hf);
  endtask

  initial begin
    step();
    step();
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_data", 64'(out_data), 64'd0);
    check_val("rst_last", 64'(out_last), 64'd0);
    check_val("rst_bready", 64'(logb_ready), 64'hf);
    check_val("rst_eready", 64'(loge_ready), 64'hf);
    check_val("rst_ovf", 64'(loge_ovf), 64'd0);
    rstn = 1'b1;

    // Single logb on channel 2 at ts=5.
    wait_ts(5);
    logb_valid = 4'b0100;
    logb_data[2*DW +: DW] = 32'hCAFE;
    step();
    logb_valid = '0;
    expect_word("t1_hdr", 32'h0000_0504, 1'b0);
    check_val("t1_hdr_bready", 64'(logb_ready), 64'h0);
    step();
    expect_word("t1_pl", 32'hCAFE, 1'b1);
    check_val("t1_pl_bready", 64'(logb_ready), 64'h0);
    step();
    expect_idle("t1_end");

    // Three logb channels plus one loge at ts=9.
    wait_ts(9);
    logb_valid = 4'b1011;
    loge_valid = 4'b0001;
    logb_data[0*DW +: DW] = 32'hA;
    logb_data[1*DW +: DW] = 32'hB;
    logb_data[3*DW +: DW] = 32'hD;
    step();
    logb_valid = '0;
    loge_valid = '0;
    expect_word("t2_hdr", 32'h0000_091B, 1'b0);
    step();
    expect_word("t2_p0", 32'hA, 1'b0);
    step();
    expect_word("t2_p1", 32'hB, 1'b0);
    step();
    expect_word("t2_p3", 32'hD, 1'b1);
    step();
    expect_idle("t2_end");

    // loge on channel 3 while busy becomes a header-only record.
    logb_valid = 4'b0011;
    logb_data[0*DW +: DW] = 32'h11;
    logb_data[1*DW +: DW] = 32'h22;
    ts_exp = tb_ts;
    step();
    logb_valid = '0;
    expect_word("t3_hdr", hdr(ts_exp, 4'h0, 4'h3), 1'b0);
    step();
    expect_word("t3_p0", 32'h11, 1'b0);
    loge_valid = 4'b1000;
    check_val("t3_eready", 64'(loge_ready), 64'hf);
    step();
    loge_valid = '0;
    expect_word("t3_p1", 32'h22, 1'b1);
    step();
    expect_idle("t3_gap");
    ts_exp = tb_ts;
    step();
    expect_word("t3_ehdr", hdr(ts_exp, 4'h8, 4'h0), 1'b1);
    step();
    expect_idle("t3_end");
    check_val("t3_ovf", 64'(loge_ovf), 64'd0);

    // Backpressure for three HDR cycles with two loge[1] pulses (overflow).
    logb_valid = 4'b0011;
    ts_exp = tb_ts;
    step();
    logb_valid = '0;
    out_ready = 1'b0;
    loge_valid = 4'b0010;
    expect_word("t4_hdr", hdr(ts_exp, 4'h0, 4'h3), 1'b0);
    step();
    loge_valid = '0;
    expect_word("t4_hold1", hdr(ts_exp, 4'h0, 4'h3), 1'b0);
    check_val("t4_hold1_bready", 64'(logb_ready), 64'h0);
    check_val("t4_ovf_first", 64'(loge_ovf), 64'd0);
    step();
    loge_valid = 4'b0010;
    expect_word("t4_hold2", hdr(ts_exp, 4'h0, 4'h3), 1'b0);
    step();
    loge_valid = '0;
    out_ready = 1'b1;
    expect_word("t4_hold3", hdr(ts_exp, 4'h0, 4'h3), 1'b0);
    check_val("t4_hold3_bready", 64'(logb_ready), 64'h0);
    check_val("t4_ovf_set", 64'(loge_ovf), 64'd1);
    step();
    expect_word("t4_p0", 32'h11, 1'b0);
    step();
    expect_word("t4_p1", 32'h22, 1'b1);
    step();
    expect_idle("t4_gap");
    ts_exp = tb_ts;
    step();
    expect_word("t4_ehdr", hdr(ts_exp, 4'h2, 4'h0), 1'b1);
    step();
    expect_idle("t4_end");
    check_val("t4_ovf_sticky", 64'(loge_ovf), 64'd1);

`ifdef RR_LOG_SCHED_STATS_EN
    check_val("stat_stall", 64'(stat_stall_cycles), 64'd3);
    check_val("stat_records", 64'(stat_records), 64'd6);
`endif

    // Reset in the middle of DATA with a pending loge.
    logb_valid = 4'b0011;
    step();
    logb_valid = '0;
    step();
    expect_word("t5_p0", 32'h11, 1'b0);
    loge_valid = 4'b0100;
    rstn = 1'b0;
    step();
    loge_valid = '0;
    rstn = 1'b1;
    expect_idle("t5_rst");
    check_val("t5_rst_data", 64'(out_data), 64'd0);
    check_val("t5_rst_last", 64'(out_last), 64'd0);
    check_val("t5_rst_ovf", 64'(loge_ovf), 64'd0);
    step();
    expect_idle("t5_nopend");
    step();
    expect_idle("t5_nopend2");
    logb_valid = 4'b0001;
    logb_data[0*DW +: DW] = 32'h55;
    step();
    logb_valid = '0;
    expect_word("t5_hdr", hdr(2, 4'h0, 4'h1), 1'b0);
    step();
    expect_word("t5_pl", 32'h55, 1'b1);
    step();
    expect_idle("t5_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
